// File: rtl/grid_io_bl_wl_programmer.sv
// Bit-line / word-line programmer for an I/O grid tile.
// Each accepted frame drives bl, pulses one wl, then releases bl.
module grid_io_bl_wl_programmer #(
    parameter int BL_WIDTH     = 8,
    parameter int WL_WIDTH     = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_wl_addr,
    input  logic [BL_WIDTH-1:0]   cfg_bl_data,
    output logic [0:BL_WIDTH-1]   bl,
    output logic [0:WL_WIDTH-1]   wl,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [15:0]           frame_cnt
);

    localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [ADDR_WIDTH:0] WL_LIM = (ADDR_WIDTH + 1)'(WL_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [0:WL_WIDTH-1]   hot;

    assign cfg_ready = (state == IDLE) && !pReset;
    assign busy      = (state != IDLE);

    always_comb begin
        hot = '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
            hot[i] = (addr_q == ADDR_WIDTH'(i));
        end
    end

    // bl carries the latched data itself, so input churn cannot reach it
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            bl        <= '0;
            wl        <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if ({1'b0, cfg_wl_addr} < WL_LIM) begin
                            addr_q <= cfg_wl_addr;
                            bl     <= cfg_bl_data;
                            cnt    <= CW'(SETUP_CYCLES - 1);
                            state  <= SETUP;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        wl    <= hot;
                        cnt   <= CW'(PULSE_CYCLES - 1);
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        wl    <= '0;
                        cnt   <= CW'(HOLD_CYCLES - 1);
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        bl       <= '0;
                        cfg_done <= 1'b1;
                        state    <= IDLE;
                        if (frame_cnt != 16'hFFFF) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_io_bl_wl_programmer.sv
// Directed bench: default instance plus a WL_WIDTH=6, 3/1/2 timing instance.
module tb_grid_io_bl_wl_programmer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, v0, rdy0, busy0, done0, err0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic [0:7] bl0, wl0;
    logic [15:0] fc0;

    logic       rst1, v1, rdy1, busy1, done1, err1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic [0:7] bl1;
    logic [0:5] wl1;
    logic [15:0] fc1;

    grid_io_bl_wl_programmer u0 (
        .prog_clk(clk), .pReset(rst0), .cfg_valid(v0), .cfg_ready(rdy0),
        .cfg_wl_addr(a0), .cfg_bl_data(d0), .bl(bl0), .wl(wl0),
        .busy(busy0), .cfg_done(done0), .cfg_err(err0), .frame_cnt(fc0)
    );

    grid_io_bl_wl_programmer #(
        .WL_WIDTH(6), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)
    ) u1 (
        .prog_clk(clk), .pReset(rst1), .cfg_valid(v1), .cfg_ready(rdy1),
        .cfg_wl_addr(a1), .cfg_bl_data(d1), .bl(bl1), .wl(wl1),
        .busy(busy1), .cfg_done(done1), .cfg_err(err1), .frame_cnt(fc1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] obs0();
        return {bl0, wl0, done0, rdy0, busy0, err0};
    endfunction

    function automatic logic [17:0] obs1();
        return {bl1, wl1, done1, rdy1, busy1, err1};
    endfunction

    typedef struct {
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [7:0]  exp_wl;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tbl[4];

    // Called at a negedge with u0 idle; checks the 5-cycle frame timeline.
    task automatic frame0(input vec_t t, input int idx);
        logic [7:0] eb, ew;
        v0 = 1'b1;
        a0 = t.addr;
        d0 = t.data;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            eb = (k <= 4) ? t.data : 8'h00;
            ew = (k == 2 || k == 3) ? t.exp_wl : 8'h00;
            chk($sformatf("frame%0d_k%0d", idx, k), 32'(obs0()),
                32'({eb, ew, k == 5, k == 5, k <= 4, 1'b0}));
            if (k == 5) chk($sformatf("frame%0d_cnt", idx), 32'(fc0), 32'(t.exp_fc));
            v0 = 1'b0;
            d0 = ~d0;
            a0 = a0 + 3'd1;
        end
    endtask

    initial begin
        int k;
        logic [7:0] eb1;
        logic [5:0] ew1;

        tbl[0] = '{addr: 3'd3, data: 8'hA5, exp_wl: 8'h10, exp_fc: 16'd1};
        tbl[1] = '{addr: 3'd0, data: 8'h3C, exp_wl: 8'h80, exp_fc: 16'd2};
        tbl[2] = '{addr: 3'd7, data: 8'hFF, exp_wl: 8'h01, exp_fc: 16'd3};
        tbl[3] = '{addr: 3'd5, data: 8'h01, exp_wl: 8'h04, exp_fc: 16'd4};

        rst0 = 1'b1; rst1 = 1'b1;
        v0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b0; a1 = '0; d1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_obs0", 32'(obs0()), 32'h0);
        chk("rst_obs1", 32'(obs1()), 32'h0);
        chk("rst_fc0", 32'(fc0), 32'h0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("idle_obs0", 32'(obs0()), 32'h4);
        chk("idle_obs1", 32'(obs1()), 32'h4);

        for (int i = 0; i < 4; i++) frame0(tbl[i], i);

        // back-to-back frames, addresses 0..7, valid held high
        v0 = 1'b1; a0 = 3'd0; d0 = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) begin
                    if (i == 7) v0 = 1'b0;
                    else begin
                        a0 = 3'(i + 1);
                        d0 = d0 + 8'h11;
                    end
                end
                if (k == 2) chk($sformatf("b2b_wl%0d", i), 32'(wl0), 32'(8'h80 >> i));
            end while (!rdy0 && k < 20);
            chk($sformatf("b2b_period%0d", i), k, 5);
            chk($sformatf("b2b_done%0d", i), 32'(done0), 32'h1);
        end
        chk("b2b_cnt", 32'(fc0), 32'd12);

        // reset during the first PULSE cycle
        v0 = 1'b1; a0 = 3'd2; d0 = 8'hC3;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        chk("mid_pulse_wl", 32'(wl0), 32'h20);
        rst0 = 1'b1;
        @(negedge clk);
        chk("mid_rst_obs", 32'(obs0()), 32'h0);
        chk("mid_rst_cnt", 32'(fc0), 32'h0);
        rst0 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", j), 32'(obs0()), 32'h4);
        end
        chk("post_rst_cnt", 32'(fc0), 32'h0);

        // out-of-range addresses on the 6-word-line instance
        v1 = 1'b1; a1 = 3'd7; d1 = 8'hEE;
        @(negedge clk);
        chk("bad7", 32'(obs1()), 32'h5);
        a1 = 3'd6;
        @(negedge clk);
        chk("bad6", 32'(obs1()), 32'h5);
        v1 = 1'b0;
        @(negedge clk);
        chk("bad_clear", 32'(obs1()), 32'h4);
        chk("bad_cnt", 32'(fc1), 32'h0);

        // 3/1/2 timing with data churn while busy
        v1 = 1'b1; a1 = 3'd5; d1 = 8'h96;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            eb1 = (j <= 6) ? 8'h96 : 8'h00;
            ew1 = (j == 4) ? 6'b000001 : 6'b000000;
            chk($sformatf("sweep_k%0d", j), 32'(obs1()),
                32'({eb1, ew1, j == 7, j == 7, j <= 6, 1'b0}));
            v1 = 1'b0;
            d1 = ~d1;
            a1 = a1 ^ 3'd3;
        end
        chk("sweep_cnt", 32'(fc1), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_io_bl_wl_programmer.md
GRID_IO_BL_WL_PROGRAMMER -- requirements
Module: grid_io_bl_wl_programmer

Interface
REQ-001 The block SHALL have parameter BL_WIDTH, default 8, giving the bit-line count driven to the I/O grid tile.
REQ-002 The block SHALL have parameter WL_WIDTH, default 8, giving the word-line count driven to the I/O grid tile.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 3, giving the word-line address width, with 2^ADDR_WIDTH >= WL_WIDTH.
REQ-004 The block SHALL have parameter SETUP_CYCLES, default 1, giving the bit-line setup time before the word-line pulse.
REQ-005 The block SHALL have parameter PULSE_CYCLES, default 2, giving the word-line pulse width.
REQ-006 The block SHALL have parameter HOLD_CYCLES, default 1, giving the bit-line hold time after the pulse; each of SETUP/PULSE/HOLD SHALL be at least 1.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-009 pReset  input  1  synchronous active-high reset.
REQ-010 cfg_valid  input  1  configuration frame offered.
REQ-011 cfg_ready  output  1  frame accepted this cycle when cfg_valid and cfg_ready are both high.
REQ-012 cfg_wl_addr  input  ADDR_WIDTH  word-line index to write.
REQ-013 cfg_bl_data  input  BL_WIDTH  bit-line data for that word.
REQ-014 bl  output  BL_WIDTH  bit lines to the grid tile, indexed [0:BL_WIDTH-1].
REQ-015 wl  output  WL_WIDTH  word lines to the grid tile, indexed [0:WL_WIDTH-1].
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 cfg_done  output  1  one-cycle pulse per completed frame.
REQ-018 cfg_err  output  1  one-cycle pulse per rejected frame.
REQ-019 frame_cnt  output  16  count of completed frames.

Function
REQ-020 States SHALL be IDLE, SETUP, PULSE and HOLD, held in one registered state register with a single down-counter for phase length.
REQ-021 cfg_ready SHALL equal (state == IDLE); it SHALL NOT depend combinationally on cfg_valid.
REQ-022 On acceptance at edge T with cfg_wl_addr < WL_WIDTH, the block SHALL latch the address and data and enter SETUP at T+1.
REQ-023 On acceptance with cfg_wl_addr >= WL_WIDTH, the block SHALL stay in IDLE, pulse cfg_err for one cycle, leave bl/wl at 0, and leave frame_cnt unchanged.
REQ-024 In SETUP, bl SHALL equal the latched data and wl SHALL be all 0, for exactly SETUP_CYCLES cycles; the block SHALL then move to PULSE.
REQ-025 In PULSE, bl SHALL hold the latched data and wl SHALL be one-hot at the latched index, for exactly PULSE_CYCLES cycles; the block SHALL then move to HOLD.
REQ-026 In HOLD, bl SHALL hold the latched data and wl SHALL be all 0, for exactly HOLD_CYCLES cycles; the block SHALL then return to IDLE.
REQ-027 In IDLE, bl and wl SHALL be all 0.
REQ-028 All of bl and wl SHALL be driven from registers (glitch-free); at most one wl bit SHALL be high in any cycle.
REQ-029 cfg_done SHALL be high for exactly the first IDLE cycle after HOLD; a new frame MAY be accepted in that same cycle.
REQ-030 With defaults, a frame accepted at T SHALL give bl valid T+1..T+4, wl high T+2..T+3, and cfg_done and cfg_ready high at T+5.
REQ-031 frame_cnt SHALL increment by 1 with each cfg_done and saturate at 16'hFFFF.
REQ-032 Changes on cfg_wl_addr/cfg_bl_data while busy SHALL have no effect on bl/wl.

Reset
REQ-033 When pReset is sampled high, at the next edge the block SHALL set state=IDLE, bl=0, wl=0, busy=0, cfg_done=0, cfg_err=0, frame_cnt=0, and cfg_ready=1 once pReset is low.
REQ-034 While pReset is high, cfg_ready SHALL be 0 and no frame SHALL be accepted.
REQ-035 Reset during SETUP/PULSE/HOLD SHALL abort the frame with no cfg_done and no frame_cnt increment.

Verification
REQ-036 Single frame, defaults: addr=3, data=8'hA5 at T -> bl=8'hA5 T+1..T+4, wl=8'b0001_0000 (index 3) T+2..T+3, cfg_done at T+5, frame_cnt=1.
REQ-037 Back-to-back: cfg_valid held high with 8 frames addr 0..7 -> frames accepted every 5 cycles, each wl index pulses once in order, frame_cnt=8.
REQ-038 Bad address: WL_WIDTH=6, addr=7 -> cfg_err for 1 cycle, bl=wl=0 throughout, frame_cnt unchanged, ready stays 1.
REQ-039 Reset mid-pulse: pReset high during PULSE cycle 1 -> bl=wl=0 next edge, no cfg_done, frame_cnt unchanged.
REQ-040 Input churn: cfg_bl_data toggled every cycle while busy -> bl stays at the latched value.
REQ-041 Parameter sweep SETUP=3, PULSE=1, HOLD=2 -> wl high exactly 1 cycle, starting 3 cycles after bl becomes valid, and bl clears 2 cycles after wl falls.
